// File: rtl/otter_dma_copy.sv
// Word-copy DMA initiator for OTTER memory port 2: one read then one write per word,
// arbitrating for the port through BUS_REQ/BUS_GNT.
module otter_dma_copy #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [31:0]      SRC_ADDR,
  input  logic [31:0]      DST_ADDR,
  input  logic [CNT_W-1:0] WORD_CNT,
  input  logic             BUS_GNT,
  input  logic [31:0]      DMA_DOUT2,
  output logic             BUS_REQ,
  output logic             DMA_RDEN2,
  output logic             DMA_WE2,
  output logic [31:0]      DMA_ADDR2,
  output logic [31:0]      DMA_DIN2,
  output logic [1:0]       DMA_SIZE,
  output logic             DMA_SIGN,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RD,
    CAP,
    WR,
    FIN
  } state_t;

  state_t           state, state_nx;
  logic [31:0]      src, dst, data;
  logic [CNT_W-1:0] cnt;
  logic             err;
  logic             misaligned;

  assign misaligned = (|SRC_ADDR[1:0]) | (|DST_ADDR[1:0]);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    BUS_REQ   = 1'b0;
    DMA_RDEN2 = 1'b0;
    DMA_WE2   = 1'b0;
    DMA_ADDR2 = '0;
    DMA_DIN2  = '0;
    BUSY      = 1'b1;
    DONE      = 1'b0;
    case (state)
      IDLE: begin
        BUSY = 1'b0;
        if (START) begin
          if (misaligned || WORD_CNT == '0) state_nx = FIN;
          else                              state_nx = REQ;
        end
      end
      REQ: begin
        BUS_REQ = 1'b1;
        if (BUS_GNT) state_nx = RD;
      end
      RD: begin
        BUS_REQ   = 1'b1;
        DMA_RDEN2 = 1'b1;
        DMA_ADDR2 = src;
        state_nx  = BUS_GNT ? CAP : REQ;
      end
      // Address stays on src so the memory keeps steering DOUT2 to this word.
      CAP: begin
        BUS_REQ   = 1'b1;
        DMA_ADDR2 = src;
        state_nx  = BUS_GNT ? WR : REQ;
      end
      WR: begin
        BUS_REQ   = 1'b1;
        DMA_ADDR2 = dst;
        DMA_DIN2  = data;
        DMA_WE2   = BUS_GNT;
        if (!BUS_GNT)                   state_nx = REQ;
        else if (cnt == CNT_W'(1))      state_nx = FIN;
        else                            state_nx = RD;
      end
      FIN: begin
        DONE     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pointers and count advance only on a granted write, so a lost grant replays the word.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      src  <= '0;
      dst  <= '0;
      cnt  <= '0;
      data <= '0;
      err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            src <= SRC_ADDR;
            dst <= DST_ADDR;
            cnt <= WORD_CNT;
            err <= misaligned;
          end
        end
        CAP: begin
          if (BUS_GNT) data <= DMA_DOUT2;
        end
        WR: begin
          if (BUS_GNT) begin
            src <= src + 32'd4;
            dst <= dst + 32'd4;
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ERR      = err;
  assign DMA_SIZE = 2'b10;
  assign DMA_SIGN = 1'b0;

endmodule

// File: tb/tb_otter_dma_copy.sv
// Scoreboard bench for otter_dma_copy: a word-addressed memory model serves reads,
// expected writes are queued at launch and popped by an independent monitor.
module tb_otter_dma_copy;
  localparam int unsigned CNT_W = 16;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             START = 1'b0;
  logic [31:0]      SRC_ADDR = '0;
  logic [31:0]      DST_ADDR = '0;
  logic [CNT_W-1:0] WORD_CNT = '0;
  logic             BUS_GNT = 1'b0;
  logic [31:0]      DMA_DOUT2;
  logic             BUS_REQ, DMA_RDEN2, DMA_WE2, DMA_SIGN, BUSY, DONE, ERR;
  logic [31:0]      DMA_ADDR2, DMA_DIN2;
  logic [1:0]       DMA_SIZE;

  otter_dma_copy #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .SRC_ADDR(SRC_ADDR),
    .DST_ADDR(DST_ADDR), .WORD_CNT(WORD_CNT), .BUS_GNT(BUS_GNT),
    .DMA_DOUT2(DMA_DOUT2), .BUS_REQ(BUS_REQ), .DMA_RDEN2(DMA_RDEN2),
    .DMA_WE2(DMA_WE2), .DMA_ADDR2(DMA_ADDR2), .DMA_DIN2(DMA_DIN2),
    .DMA_SIZE(DMA_SIZE), .DMA_SIGN(DMA_SIGN), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Synchronous-read memory; DOUT2 holds the last granted read.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rdata = '0;
  assign DMA_DOUT2 = rdata;

  always @(posedge CLK) begin
    if (DMA_RDEN2 && BUS_GNT)
      rdata <= mem.exists(DMA_ADDR2) ? mem[DMA_ADDR2] : 32'hDEAD_BEEF;
  end

  always @(posedge CLK) begin
    if (DMA_WE2 && BUS_GNT) mem[DMA_ADDR2] = DMA_DIN2;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  wr_t         e;
  logic [31:0] ref_vals[$];
  logic [31:0] rd_addrs[$];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0, start_cyc = 0, first_rd = -1, done_cyc = 0;
  int rd_cnt = 0, we_cnt = 0, io_cnt = 0, nogrant = 0, done_cnt = 0;
  logic done_err = 1'b0;
  bit   gnt_rand = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: samples on the falling edge, pops one expected write per WE2 cycle.
  always @(negedge CLK) begin
    cyc++;
    if (START) start_cyc = cyc;
    if (DMA_RDEN2) begin
      rd_cnt++;
      rd_addrs.push_back(DMA_ADDR2);
      if (first_rd < 0) first_rd = cyc;
    end
    if (DMA_WE2) begin
      we_cnt++;
      if (!BUS_GNT) nogrant++;
      if (DMA_ADDR2 >= 32'h0001_0000) io_cnt++;
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write",
                 DMA_ADDR2, DMA_DIN2);
      end else begin
        e = sb.pop_front();
        check("wr_addr", DMA_ADDR2, e.addr);
        check("wr_data", DMA_DIN2, e.data);
      end
    end
    if (DONE) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = ERR;
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (gnt_rand) BUS_GNT = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic clear_stats();
    rd_cnt = 0; we_cnt = 0; io_cnt = 0; done_cnt = 0; first_rd = -1;
    rd_addrs.delete();
    ref_vals.delete();
  endtask

  // Reference model: a copy of n words means writes to d+4i of whatever sat at s+4i.
  task automatic launch(input logic [31:0] s, input logic [31:0] d,
                        input int unsigned n, input bit expect_copy);
    logic [31:0] v;
    @(posedge CLK);
    #1;
    clear_stats();
    if (expect_copy) begin
      for (int unsigned i = 0; i < n; i++) begin
        v = $urandom;
        mem[s + 32'(4 * i)] = v;
        ref_vals.push_back(v);
        sb.push_back('{addr: d + 32'(4 * i), data: v});
      end
    end
    SRC_ADDR = s;
    DST_ADDR = d;
    WORD_CNT = CNT_W'(n);
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic wait_done(input int unsigned maxc);
    bit seen = 1'b0;
    for (int unsigned i = 0; i < maxc && !seen; i++) begin
      @(posedge CLK);
      #1;
      seen = (done_cnt != 0);
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: got no DONE expected DONE within %0d cycles", maxc);
    end
  endtask

  task automatic check_dest(input logic [31:0] d);
    for (int unsigned i = 0; i < ref_vals.size(); i++)
      check("dest_mem", mem.exists(d + 32'(4 * i)) ? mem[d + 32'(4 * i)] : 32'hxxxx_xxxx,
            ref_vals[i]);
  endtask

  initial begin
    bit hit;
    logic [31:0] s, d;
    int unsigned n;

    repeat (3) @(posedge CLK);
    #1;
    check("rst_bus_req", 32'(BUS_REQ), 32'd0);
    check("rst_rden", 32'(DMA_RDEN2), 32'd0);
    check("rst_we", 32'(DMA_WE2), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_addr", DMA_ADDR2, 32'd0);
    check("rst_din", DMA_DIN2, 32'd0);
    check("size_const", 32'(DMA_SIZE), 32'd2);
    check("sign_const", 32'(DMA_SIGN), 32'd0);
    RST_N = 1'b1;
    BUS_GNT = 1'b1;

    // Basic 4-word copy with permanent grant
    launch(32'h100, 32'h200, 4, 1'b1);
    wait_done(100);
    check("t1_rd_latency", 32'(first_rd - start_cyc), 32'd2);
    check("t1_done_timing", 32'(done_cyc - first_rd), 32'd12);
    check("t1_rd_cnt", 32'(rd_cnt), 32'd4);
    check("t1_we_cnt", 32'(we_cnt), 32'd4);
    check("t1_err", 32'(done_err), 32'd0);
    check("t1_busy_after", 32'(BUSY), 32'd0);
    check_dest(32'h200);

    // Zero-length copy
    launch(32'h300, 32'h400, 0, 1'b0);
    wait_done(20);
    check("t2_done_timing", 32'(done_cyc - start_cyc), 32'd1);
    check("t2_rd_cnt", 32'(rd_cnt), 32'd0);
    check("t2_we_cnt", 32'(we_cnt), 32'd0);
    check("t2_err", 32'(done_err), 32'd0);

    // Misaligned source, then misaligned destination, then recovery
    launch(32'h102, 32'h200, 4, 1'b0);
    wait_done(20);
    check("t3_rd_cnt", 32'(rd_cnt), 32'd0);
    check("t3_we_cnt", 32'(we_cnt), 32'd0);
    check("t3_err_with_done", 32'(done_err), 32'd1);
    repeat (3) @(posedge CLK);
    #1;
    check("t3_err_sticky", 32'(ERR), 32'd1);
    launch(32'h100, 32'h201, 2, 1'b0);
    wait_done(20);
    check("t3_dst_err", 32'(done_err), 32'd1);
    check("t3_dst_we_cnt", 32'(we_cnt), 32'd0);
    launch(32'h600, 32'h700, 1, 1'b1);
    check("t3_err_cleared", 32'(ERR), 32'd0);
    check("t3_busy", 32'(BUSY), 32'd1);
    wait_done(50);
    check("t3_ok_err", 32'(done_err), 32'd0);

    // Grant lost for 5 cycles during CAP of word 2 of 3
    launch(32'h800, 32'h900, 3, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(posedge CLK);
      #1;
      hit = (rd_cnt == 2);
    end
    check("t4_reached_word2", 32'(hit), 32'd1);
    BUS_GNT = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    BUS_GNT = 1'b1;
    wait_done(100);
    check("t4_rd_cnt", 32'(rd_cnt), 32'd4);
    check("t4_we_cnt", 32'(we_cnt), 32'd3);
    check("t4_nogrant", 32'(nogrant), 32'd0);
    check_dest(32'h900);

    // Source wraps past the top of the address space; destination is MMIO
    launch(32'hFFFF_FFFC, 32'h0001_0000, 2, 1'b1);
    wait_done(50);
    check("t5_rd_cnt", 32'(rd_cnt), 32'd2);
    if (rd_addrs.size() >= 2) begin
      check("t5_rd_addr0", rd_addrs[0], 32'hFFFF_FFFC);
      check("t5_rd_addr1", rd_addrs[1], 32'h0000_0000);
    end
    check("t5_io_writes", 32'(io_cnt), 32'd2);

    // Asynchronous reset during the write of word 2 of 4
    launch(32'hA00, 32'hB00, 4, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(posedge CLK);
      #1;
      hit = DMA_WE2 && (rd_cnt == 2);
    end
    check("t6_reached_wr2", 32'(hit), 32'd1);
    #1;
    RST_N = 1'b0;
    #1;
    check("t6_we_drop", 32'(DMA_WE2), 32'd0);
    check("t6_req_drop", 32'(BUS_REQ), 32'd0);
    check("t6_busy_drop", 32'(BUSY), 32'd0);
    check("t6_we_cnt", 32'(we_cnt), 32'd1);
    check("t6_word0_kept", mem.exists(32'hB00) ? mem[32'hB00] : 32'hxxxx_xxxx, ref_vals[0]);
    sb.delete();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check("t6_idle_after", 32'(BUSY), 32'd0);
    launch(32'hC00, 32'hD00, 2, 1'b1);
    wait_done(50);
    check("t6_restart_we", 32'(we_cnt), 32'd2);
    check_dest(32'hD00);

    // Randomised copies under a randomly toggling grant
    gnt_rand = 1'b1;
    for (int t = 0; t < 8; t++) begin
      s = 32'h1000 + 32'(4 * $urandom_range(0, 1000));
      d = 32'h8000 + 32'(4 * $urandom_range(0, 1000));
      n = $urandom_range(1, 8);
      launch(s, d, n, 1'b1);
      wait_done(2000);
      check("rand_we_cnt", 32'(we_cnt), 32'(n));
      check("rand_err", 32'(done_err), 32'd0);
      check_dest(d);
    end
    gnt_rand = 1'b0;
    @(posedge CLK);
    #1;
    BUS_GNT = 1'b1;
    check("total_nogrant", 32'(nogrant), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
